cnn_stage_sequencer: RTL and testbench
======================================

# cnn_stage_sequencer

Parametrised stage sequencer for the CNN datapath. It releases the active-high resets of N_STAGES pipeline stages (conv, tanh, avg-pool, …) one after another, in order. Each stage advances either after a fixed cycle budget or on the stage's own completion flag, with the budget acting as a timeout. It replaces a hard-coded cycle-count reset schedule in the integration top level, and adds start, abort and restart control plus status and timeout reporting.

## Interface
Parameters:
- N_STAGES, default 8: number of sequenced stages.
- CNT_W, default 20: width of each per-stage budget and of the internal counter.
- IDX_W, default $clog2(N_STAGES): stage index width (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request, single-cycle pulse; ignored while busy.
- abort  in  1  abort request; returns the block to IDLE.
- budget  in  N_STAGES*CNT_W  budget for stage k in [k*CNT_W +: CNT_W].
- use_done  in  N_STAGES  per-stage mode: 1 = advance on stage_done (budget is a timeout); 0 = advance after a fixed count.
- stage_done  in  N_STAGES  completion flag from each stage; level-sampled.
- stage_rst  out  N_STAGES  active-high reset to each stage.
- cur_stage  out  IDX_W  index of the stage currently being timed.
- busy  out  1  high while a sequence is in progress.
- seq_done  out  1  one-cycle pulse when the last stage completes.
- timeout  out  1  sticky; set when any done-mode stage exceeds its budget.
- timeout_stage  out  IDX_W  index of the first stage that timed out.

## Operation
- States: IDLE, RUN, DONE, FLUSH.
- Reset values: stage_rst all 1s; cur_stage 0; busy 0; seq_done 0; timeout 0; timeout_stage 0; state IDLE.
- IDLE:
  - All stage_rst high.
  - On start: go to RUN with cur_stage=0. stage_rst[0] goes low, the counter loads budget[0], and timeout/timeout_stage clear.
- RUN, stage k: the counter decrements once per cycle. Stage k completes when either condition holds:
  - count mode (use_done[k]=0): the stage has been active for exactly budget[k] cycles. budget 0 is treated as 1.
  - done mode (use_done[k]=1): stage_done[k] is sampled high.
    - If budget[k] cycles elapse without done, the stage completes anyway. timeout is set, and timeout_stage is latched to k only if timeout was previously 0.
    - budget 0 means no timeout (wait forever).
- On stage completion:
  - If k<N_STAGES-1: clear stage_rst[k+1], increment cur_stage, reload the counter with budget[k+1].
  - Otherwise: go to DONE.
- Released stages stay released (stage_rst[j]=0 for j≤k) for the rest of the sequence.
- DONE:
  - seq_done is high for the single cycle of entry into DONE.
  - All stages remain released and busy=0; cur_stage holds N_STAGES-1.
  - On start: go to FLUSH.
- FLUSH: all stage_rst high for exactly one cycle, then RUN at stage 0, identical to a start from IDLE.
- abort, from any state: all stage_rst high, state IDLE, no seq_done. timeout is retained.
- abort and start in the same cycle: abort wins.
- start while in RUN or FLUSH: ignored.
- stage_done[j] for j≠cur_stage: ignored.
- budget and use_done are sampled at the counter load, so mid-stage changes have no effect on the current stage.
- Asserting reset mid-sequence forces the reset values immediately (asynchronous assert); the block leaves reset on the clock edge after deassertion.

## Timing
- From IDLE, start sampled at edge E0: stage_rst[0]=0 and busy=1 after E0.
- Count mode: stage k+1 is released after edge E0 + sum(budget[0..k]). seq_done is high in the cycle following edge E0 + sum(all budgets); busy drops in the same cycle.
- Done mode: stage_done[k] high at edge E releases stage k+1 after E, with zero added latency.
- Timeout: stage released at edge R with no done by edge R+budget[k]. timeout rises and stage k+1 is released after edge R+budget[k].
- Restart from DONE costs one extra cycle (FLUSH).
- All outputs are registered.

## Structure
- Shared package cnn_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE, FLUSH};
  - the idx_width function;
  - default budget constants for the LeNet layer chain (C1, Tanh1, AP1, C2, Tanh2, AP2, C3, Tanh3).
- One sub-module is natural: stage_timer, a loadable down-counter with a zero-budget bypass and an expiry flag.

## Test plan
- N_STAGES=4, CNT_W=8, count mode, budgets {3,5,2,4}, start at E0:
  - stage_rst goes 1111→1110 after E0, →1100 after E0+3, →1000 after E0+8, →0000 after E0+10;
  - seq_done pulses after E0+14.
- Done mode, all budgets 10, stage_done[k] asserted 2 cycles after each release: each stage advances 2 cycles after its release; timeout stays 0.
- Done mode, stage 2 never asserts done, budget[2]=6: timeout=1 and timeout_stage=2 six cycles after stage 2 is released; stage 3 is then released and the sequence completes.
- abort during stage 2: stage_rst returns to 1111 on the next edge and busy=0. A start asserted in the same cycle as abort is ignored; no seq_done.
- Restart from DONE: FLUSH shows stage_rst=1111 for one cycle, then stage 0 is released.
- Reset asserted mid-RUN: all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN stage sequencer: FSM states, index
// width helper and the default per-layer cycle budgets of the LeNet chain.
package cnn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FLUSH
  } seq_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Budgets roughly track the output-pixel count of each LeNet layer
  localparam logic [19:0] C1_BUDGET    = 20'd4704;
  localparam logic [19:0] TANH1_BUDGET = 20'd4704;
  localparam logic [19:0] AP1_BUDGET   = 20'd1176;
  localparam logic [19:0] C2_BUDGET    = 20'd1600;
  localparam logic [19:0] TANH2_BUDGET = 20'd1600;
  localparam logic [19:0] AP2_BUDGET   = 20'd400;
  localparam logic [19:0] C3_BUDGET    = 20'd120;
  localparam logic [19:0] TANH3_BUDGET = 20'd120;

  localparam logic [8*20-1:0] LENET_BUDGETS = {
    TANH3_BUDGET, C3_BUDGET, AP2_BUDGET, TANH2_BUDGET,
    C2_BUDGET, AP1_BUDGET, TANH1_BUDGET, C1_BUDGET
  };

endpackage

// File: rtl/cnn_stage_sequencer_timer.sv
// Loadable per-stage down-counter. Expires on the edge that completes the
// loaded number of active cycles; a zero budget counts as one cycle unless
// the stage waits on its done flag, in which case the timer never expires.
module stage_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             wait_on_zero,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;
  logic             hold;

  // Count saturates at 1 so expiry stays asserted until the next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hold <= 1'b1;
    end else if (load) begin
      cnt  <= (load_val == '0) ? CNT_W'(1) : load_val;
      hold <= wait_on_zero && (load_val == '0);
    end else if (cnt > CNT_W'(1)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = !hold && (cnt == CNT_W'(1));

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Releases the resets of N_STAGES pipeline stages in order, each stage
// advancing on a fixed budget or on its done flag with the budget as timeout.
module cnn_stage_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int N_STAGES = 8,
  parameter int CNT_W    = 20,
  parameter int IDX_W    = idx_width(N_STAGES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_STAGES*CNT_W-1:0] budget,
  input  logic [N_STAGES-1:0]       use_done,
  input  logic [N_STAGES-1:0]       stage_done,
  output logic [N_STAGES-1:0]       stage_rst,
  output logic [IDX_W-1:0]          cur_stage,
  output logic                      busy,
  output logic                      seq_done,
  output logic                      timeout,
  output logic [IDX_W-1:0]          timeout_stage
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STAGES - 1);

  seq_state_e            state_q, state_d;
  logic                  mode_q;
  logic                  expired;
  logic                  stage_complete;
  logic                  stage_timed_out;
  logic                  load;
  logic [IDX_W-1:0]      load_idx;
  logic [CNT_W-1:0]      load_val;
  logic [IDX_W-1:0]      cur_d;
  logic [IDX_W-1:0]      tstage_d;
  logic [N_STAGES-1:0]   rst_d;
  logic                  busy_d;
  logic                  seq_done_d;
  logic                  timeout_d;

  // Outside RUN every load is the stage-0 load of a fresh sequence
  assign load_idx = (state_q == RUN && cur_stage != LAST) ? cur_stage + IDX_W'(1) : '0;
  assign load_val = budget[int'(load_idx)*CNT_W +: CNT_W];

  assign stage_complete  = (state_q == RUN) && (expired || (mode_q && stage_done[cur_stage]));
  assign stage_timed_out = (state_q == RUN) && mode_q && expired && !stage_done[cur_stage];

  stage_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .wait_on_zero(use_done[load_idx]),
    .expired     (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort overrides everything, including a start in the same cycle
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stage_complete && cur_stage == LAST) state_d = DONE;
        DONE:    if (start) state_d = FLUSH;
        FLUSH:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load      = 1'b0;
    cur_d     = cur_stage;
    timeout_d = timeout;
    tstage_d  = timeout_stage;
    if (!abort) begin
      if ((state_q == IDLE && start) || state_q == FLUSH) begin
        load      = 1'b1;
        timeout_d = 1'b0;
        tstage_d  = '0;
      end else if (stage_complete && cur_stage != LAST) begin
        load  = 1'b1;
        cur_d = cur_stage + IDX_W'(1);
      end
      if (stage_timed_out) begin
        timeout_d = 1'b1;
        if (!timeout) tstage_d = cur_stage;
      end
    end
    if (state_d != RUN && state_d != DONE) cur_d = '0;

    busy_d     = (state_d == RUN) || (state_d == FLUSH);
    seq_done_d = (state_d == DONE) && (state_q == RUN);

    rst_d = '1;
    if (state_d == DONE) begin
      rst_d = '0;
    end else if (state_d == RUN) begin
      for (int j = 0; j < N_STAGES; j++) rst_d[j] = (j > int'(cur_d));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_rst     <= '1;
      cur_stage     <= '0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      timeout       <= 1'b0;
      timeout_stage <= '0;
      mode_q        <= 1'b0;
    end else begin
      stage_rst     <= rst_d;
      cur_stage     <= cur_d;
      busy          <= busy_d;
      seq_done      <= seq_done_d;
      timeout       <= timeout_d;
      timeout_stage <= tstage_d;
      if (load) mode_q <= use_done[load_idx];
    end
  end

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer with 4 stages and 8-bit budgets: a cycle table,
// directed done-mode/timeout/reset sequences, then random traffic vs a model.
module tb_cnn_stage_sequencer;

  localparam int N  = 4;
  localparam int CW = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic [N*CW-1:0] budget;
  logic [N-1:0]    use_done;
  logic [N-1:0]    stage_done;
  logic [N-1:0]    stage_rst;
  logic [1:0]      cur_stage;
  logic            busy;
  logic            seq_done;
  logic            timeout;
  logic [1:0]      timeout_stage;

  int vectors;
  int miscompares;

  cnn_stage_sequencer #(
    .N_STAGES(N),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .budget       (budget),
    .use_done     (use_done),
    .stage_done   (stage_done),
    .stage_rst    (stage_rst),
    .cur_stage    (cur_stage),
    .busy         (busy),
    .seq_done     (seq_done),
    .timeout      (timeout),
    .timeout_stage(timeout_stage)
  );

  always #5 clk = ~clk;

  // Reference model: tracks elapsed cycles in the active stage
  bit m_running, m_finished, m_flushing, m_seqdone, m_timeout, m_mode;
  int m_stage, m_elapsed, m_budget, m_tstage;

  function automatic void modelReset();
    m_running = 0; m_finished = 0; m_flushing = 0; m_seqdone = 0;
    m_timeout = 0; m_mode = 0; m_stage = 0; m_elapsed = 0; m_budget = 0; m_tstage = 0;
  endfunction

  function automatic void beginStage(input int k);
    m_stage   = k;
    m_elapsed = 0;
    m_budget  = int'(budget[k*CW +: CW]);
    m_mode    = use_done[k];
  endfunction

  function automatic void modelStep();
    bit hit, expired;
    m_seqdone = 0;
    if (!reset) begin
      modelReset();
    end else if (abort) begin
      m_running = 0; m_finished = 0; m_flushing = 0; m_stage = 0;
    end else if (m_running) begin
      m_elapsed++;
      hit = m_mode && stage_done[m_stage];
      if (m_mode) expired = (m_budget != 0) && (m_elapsed >= m_budget);
      else        expired = m_elapsed >= ((m_budget == 0) ? 1 : m_budget);
      if (hit || expired) begin
        if (m_mode && !hit) begin
          if (!m_timeout) m_tstage = m_stage;
          m_timeout = 1;
        end
        if (m_stage == N - 1) begin
          m_running = 0; m_finished = 1; m_seqdone = 1;
        end else begin
          beginStage(m_stage + 1);
        end
      end
    end else if (m_flushing) begin
      m_flushing = 0; m_running = 1; m_timeout = 0; m_tstage = 0;
      beginStage(0);
    end else if (m_finished) begin
      if (start) begin
        m_finished = 0; m_flushing = 1;
      end
    end else if (start) begin
      m_running = 1; m_timeout = 0; m_tstage = 0;
      beginStage(0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [N-1:0] d);
    start      = s;
    abort      = a;
    stage_done = d;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] e_rst, input logic [1:0] e_cur,
                             input logic e_busy, input logic e_sd, input logic e_tmo,
                             input logic [1:0] e_ts);
    vectors++;
    if ({stage_rst, cur_stage, busy, seq_done, timeout, timeout_stage} !==
        {e_rst, e_cur, e_busy, e_sd, e_tmo, e_ts}) begin
      miscompares++;
      $display("[TB] FAIL %s: got rst=%b cur=%0d busy=%b seq_done=%b timeout=%b tstage=%0d, expected rst=%b cur=%0d busy=%b seq_done=%b timeout=%b tstage=%0d",
               name, stage_rst, cur_stage, busy, seq_done, timeout, timeout_stage,
               e_rst, e_cur, e_busy, e_sd, e_tmo, e_ts);
    end
  endtask

  task automatic checkModel(input string name);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = m_running ? (j > m_stage) : !m_finished;
    checkOutput(name, r, m_running ? 2'(m_stage) : (m_finished ? 2'(N - 1) : 2'd0),
                m_running || m_flushing, m_seqdone, m_timeout, 2'(m_tstage));
  endtask

  typedef struct {
    logic         start;
    logic         abort;
    logic [N-1:0] rst;
    logic [1:0]   cur;
    logic         busy;
    logic         sd;
  } vec_t;

  vec_t table_q[$];

  function automatic void addVec(input int n, input logic s, input logic a, input logic [N-1:0] r,
                                 input logic [1:0] c, input logic b, input logic sd);
    vec_t v;
    v.start = s; v.abort = a; v.rst = r; v.cur = c; v.busy = b; v.sd = sd;
    for (int i = 0; i < n; i++) table_q.push_back(v);
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0;
    clk = 0; reset = 1; start = 0; abort = 0;
    budget = '0; use_done = '0; stage_done = '0;
    modelReset();

    #1 reset = 0;
    #1 checkOutput("reset_async", 4'hF, 2'd0, 0, 0, 0, 2'd0);
    tick();
    checkOutput("reset_hold", 4'hF, 2'd0, 0, 0, 0, 2'd0);
    reset = 1;
    tick();
    checkOutput("idle", 4'hF, 2'd0, 0, 0, 0, 2'd0);

    // Count mode {3,5,2,4}; done flags held high must be ignored
    budget   = {8'd4, 8'd2, 8'd5, 8'd3};
    use_done = 4'b0000;
    addVec(1, 1, 0, 4'b1110, 2'd0, 1, 0);
    addVec(2, 0, 0, 4'b1110, 2'd0, 1, 0);
    addVec(5, 0, 0, 4'b1100, 2'd1, 1, 0);
    addVec(2, 0, 0, 4'b1000, 2'd2, 1, 0);
    addVec(4, 0, 0, 4'b0000, 2'd3, 1, 0);
    addVec(1, 0, 0, 4'b0000, 2'd3, 0, 1);
    addVec(1, 0, 0, 4'b0000, 2'd3, 0, 0);
    addVec(1, 1, 0, 4'b1111, 2'd0, 1, 0);
    addVec(3, 1, 0, 4'b1110, 2'd0, 1, 0);
    addVec(5, 0, 0, 4'b1100, 2'd1, 1, 0);
    addVec(1, 0, 0, 4'b1000, 2'd2, 1, 0);
    addVec(1, 1, 1, 4'b1111, 2'd0, 0, 0);
    addVec(2, 0, 0, 4'b1111, 2'd0, 0, 0);
    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i].start, table_q[i].abort, 4'hF);
      tick();
      checkOutput($sformatf("table[%0d]", i), table_q[i].rst, table_q[i].cur,
                  table_q[i].busy, table_q[i].sd, 1'b0, 2'd0);
    end

    // Done mode: each stage_done arrives two cycles after its release
    budget   = {4{8'd10}};
    use_done = 4'b1111;
    applyStimulus(1, 0, 4'b0);
    tick();
    checkOutput("dm_start", 4'b1110, 2'd0, 1, 0, 0, 2'd0);
    for (int k = 0; k < N; k++) begin
      applyStimulus(0, 0, 4'b0);
      tick();
      checkOutput($sformatf("dm_wait%0d", k), 4'(4'hF << (k + 1)), 2'(k), 1, 0, 0, 2'd0);
      applyStimulus(0, 0, 4'(1 << k));
      tick();
      if (k < N - 1)
        checkOutput($sformatf("dm_adv%0d", k), 4'(4'hF << (k + 2)), 2'(k + 1), 1, 0, 0, 2'd0);
      else
        checkOutput("dm_last", 4'b0000, 2'd3, 0, 1, 0, 2'd0);
    end
    applyStimulus(0, 1, 4'b0);
    tick();
    checkOutput("dm_abort", 4'hF, 2'd0, 0, 0, 0, 2'd0);

    // Stage 2 never reports done; other stages' flags must not help it
    budget = {8'd10, 8'd6, 8'd10, 8'd10};
    applyStimulus(1, 0, 4'b0);
    tick();
    applyStimulus(0, 0, 4'b0001);
    tick();
    applyStimulus(0, 0, 4'b0010);
    tick();
    checkOutput("to_stage2", 4'b1000, 2'd2, 1, 0, 0, 2'd0);
    applyStimulus(0, 0, 4'b1011);
    for (int c = 1; c < 6; c++) begin
      tick();
      checkOutput($sformatf("to_wait%0d", c), 4'b1000, 2'd2, 1, 0, 0, 2'd0);
    end
    tick();
    checkOutput("to_expire", 4'b0000, 2'd3, 1, 0, 1, 2'd2);
    tick();
    checkOutput("to_done", 4'b0000, 2'd3, 0, 1, 1, 2'd2);
    applyStimulus(0, 1, 4'b0);
    tick();
    checkOutput("to_abort_keeps", 4'hF, 2'd0, 0, 0, 1, 2'd2);
    applyStimulus(1, 0, 4'b0);
    tick();
    checkOutput("to_start_clears", 4'b1110, 2'd0, 1, 0, 0, 2'd0);
    applyStimulus(0, 1, 4'b0);
    tick();
    checkOutput("to_idle", 4'hF, 2'd0, 0, 0, 0, 2'd0);

    // Asynchronous reset in the middle of stage 1
    budget   = {8'd4, 8'd2, 8'd5, 8'd3};
    use_done = 4'b0000;
    applyStimulus(1, 0, 4'b0);
    tick();
    applyStimulus(0, 0, 4'b0);
    repeat (3) tick();
    checkOutput("pre_reset", 4'b1100, 2'd1, 1, 0, 0, 2'd0);
    #2 reset = 0;
    #1 checkOutput("reset_mid_run", 4'hF, 2'd0, 0, 0, 0, 2'd0);
    tick();
    reset = 1;
    tick();
    checkOutput("reset_release", 4'hF, 2'd0, 0, 0, 0, 2'd0);

    // Random traffic, including mid-stage budget and mode changes
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < N; k++) budget[k*CW +: CW] = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) use_done = 4'($urandom);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, 4'($urandom & $urandom));
      tick();
      checkModel($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
